// File: rtl/try_splitter.sv
// ----------------------------------------------------------------------------
// try_splitter
//   Registered 256-to-8 priority encoder for the splitter datapath. Reports
//   the bit index of the most-significant set bit of a 256-bit word, plus a
//   flag that the word was nonzero. The encode is split into 16 segments of
//   16 bits. Each segment gets a 16->4 priority encoder and a nonzero flag.
//   A second 16->4 encoder over the segment flags then picks the highest
//   nonzero segment.
//
//   Ports:
//     clk    in   1    rising-edge clock
//     reset  in   1    synchronous, active-high reset (clears all registers)
//     in     in   256  word to encode, bit 0 is LSB
//     out    out  8    index of highest set bit (0 when in == 0), registered
//     valid  out  1    1 when the sampled word was nonzero, registered
//
//   Build option:
//     TRY_PIPE2_EN  when defined, segment results are registered in a first
//                   stage (latency 2). Otherwise the whole encode feeds the
//                   output register directly (latency 1).
// ----------------------------------------------------------------------------
module try_splitter (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] in,
    output logic [7:0]   out,
    output logic         valid
);

    // Index of the highest set bit of a 16-bit value. Returns 0 for a zero
    // input. The ascending scan lets the highest set bit overwrite the others.
    function automatic logic [3:0] prio16(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Per-segment encode.
    logic [15:0][3:0] seg_idx_d;
    logic [15:0]      seg_nz_d;

    always_comb begin
        seg_idx_d = '0;
        seg_nz_d  = '0;
        for (int unsigned s = 0; s < 16; s++) begin
            seg_idx_d[s] = prio16(in[s*16 +: 16]);
            seg_nz_d[s]  = |in[s*16 +: 16];
        end
    end

    // Segment results as seen by the selection stage.
    logic [15:0][3:0] seg_idx_src;
    logic [15:0]      seg_nz_src;

`ifdef TRY_PIPE2_EN
    logic [15:0][3:0] seg_idx_q;
    logic [15:0]      seg_nz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_idx_q <= '0;
            seg_nz_q  <= '0;
        end else begin
            seg_idx_q <= seg_idx_d;
            seg_nz_q  <= seg_nz_d;
        end
    end

    always_comb begin
        seg_idx_src = seg_idx_q;
        seg_nz_src  = seg_nz_q;
    end
`else
    always_comb begin
        seg_idx_src = seg_idx_d;
        seg_nz_src  = seg_nz_d;
    end
`endif

    // Segment selection. With no segment set, sel is 0 and segment 0's index
    // is 0 as well, so out falls to 0 with no extra masking.
    logic [3:0] sel;
    logic [7:0] out_d;
    logic       valid_d;
    logic [7:0] out_q;
    logic       valid_q;

    always_comb begin
        sel     = prio16(seg_nz_src);
        out_d   = {sel, seg_idx_src[sel]};
        valid_d = |seg_nz_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_try_splitter.sv
module tb_try_splitter;

`ifdef TRY_PIPE2_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] din;
    logic [7:0]   dout;
    logic         dvalid;

    try_splitter dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .out   (dout),
        .valid (dvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [7:0]   o;
        logic         v;
        string        tag;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        logic       v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [7:0] eo, input logic ev);
        total++;
        if (dout !== eo || dvalid !== ev) begin
            bad++;
            $display("FAIL %s: got out=%0d valid=%b, want out=%0d valid=%b",
                     tag, dout, dvalid, eo, ev);
        end
    endtask

    // Drive one word for one cycle; compare whichever result is due now.
    task automatic step(input logic [255:0] d, input logic [7:0] eo,
                        input logic ev, input string tag);
        exp_t e;
        reset = 1'b0;
        din   = d;
        e.o   = eo;
        e.v   = ev;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= LAT) begin
            e = q.pop_front();
            check(e.tag, e.o, e.v);
        end
    endtask

    // Hold reset for n cycles with word d on the input; drop in-flight
    // expectations and expect zeros until the pipeline refills.
    task automatic do_reset(input int n, input logic [255:0] d);
        exp_t z;
        q.delete();
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            din   = d;
            @(posedge clk);
            #1;
            check("in_reset", 8'd0, 1'b0);
        end
        reset = 1'b0;
        z.o   = 8'd0;
        z.v   = 1'b0;
        z.tag = "post_reset";
        for (int unsigned i = 1; i < LAT; i++) q.push_back(z);
    endtask

    function automatic void ref_enc(input logic [255:0] d, output logic [7:0] o,
                                    output logic v);
        o = 8'd0;
        v = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (d[i]) begin
                o = 8'(i);
                v = 1'b1;
                break;
            end
        end
    endfunction

    vec_t         vecs[$];
    vec_t         tv;
    logic [255:0] one;
    logic [255:0] rd;
    logic [7:0]   ro;
    logic         rv;

    initial begin
        reset = 1'b1;
        din   = '0;
        one   = 256'd1;

        vecs.push_back('{256'd0,                 8'd0,   1'b0, "zero"});
        vecs.push_back('{256'b110,               8'd2,   1'b1, "b110"});
        vecs.push_back('{one,                    8'd0,   1'b1, "bit0"});
        vecs.push_back('{one << 255,             8'd255, 1'b1, "bit255"});
        vecs.push_back('{one << 16,              8'd16,  1'b1, "bit16"});
        vecs.push_back('{(one << 15) | one,      8'd15,  1'b1, "bit15_and_0"});
        vecs.push_back('{(one << 17) | (one << 16), 8'd17, 1'b1, "bit17_16"});
        vecs.push_back('{(one << 240) | (one << 239), 8'd240, 1'b1, "seg15_lsb"});
        vecs.push_back('{{16'd0, {240{1'b1}}},   8'd239, 1'b1, "low240"});
        vecs.push_back('{one << 127,             8'd127, 1'b1, "bit127"});
        vecs.push_back('{'1,                     8'd255, 1'b1, "all_ones_t"});
        vecs.push_back('{(one << 1) | one,       8'd1,   1'b1, "bit1_0"});

        // Reset for 2 cycles with all-ones input, then release.
        do_reset(2, '1);
        step('1, 8'd255, 1'b1, "all_ones");

        // Directed table, applied back to back.
        foreach (vecs[i]) begin
            tv = vecs[i];
            step(tv.d, tv.o, tv.v, tv.tag);
        end

        // Back-to-back stream with a 1-cycle reset in the middle.
        step(one << 3,   8'd3,   1'b1, "s_b3");
        step(one << 200, 8'd200, 1'b1, "s_b200");
        do_reset(1, one << 77);
        step(256'd0,     8'd0,   1'b0, "s_zero");
        step(one << 128, 8'd128, 1'b1, "s_b128");
        step(one << 3,   8'd3,   1'b1, "s2_b3");
        step(one << 200, 8'd200, 1'b1, "s2_b200");
        step(256'd0,     8'd0,   1'b0, "s2_zero");
        step(one << 128, 8'd128, 1'b1, "s2_b128");

        // Random sweep against the bit-scan reference.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
            rd = rd >> $urandom_range(0, 255);
            if ($urandom_range(0, 19) == 0) rd = '0;
            ref_enc(rd, ro, rv);
            step(rd, ro, rv, "rand");
        end

        // Flush the pipeline.
        for (int unsigned i = 0; i < LAT; i++) step(256'd0, 8'd0, 1'b0, "flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
